rca_nibble_seq: RTL and testbench



---
 rtl/rca_nibble_seq.sv | 130 +++++++++++++
 tb/tb_rca_nibble_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rca_nibble_seq.sv
// rca_nibble_seq -- multi-cycle wide adder built from one 4-bit ripple-carry slice.
//
// A WIDTH-bit addition a + b + cin is computed one nibble per clock. The carry
// between nibbles is kept in a register. Results leave through a valid/ready
// handshake, and new operands are taken through a second valid/ready handshake.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a/b/cin valid
//   in_ready   out  block can accept operands (registered, high only in IDLE)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry into nibble 0
//   out_valid  out  sum/cout/ovf valid
//   out_ready  in   consumer accepts the result
//   sum        out  a + b + cin modulo 2^WIDTH (partial nibbles visible while busy)
//   cout       out  carry out of bit WIDTH-1
//   ovf        out  signed overflow (carry into MSB xor carry out of MSB)
module rca_nibble_seq #(
    parameter int WIDTH = 16,
    localparam int NIB = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;

    // Operand registers shift right every step, so the active nibble is
    // always in the low four bits.
    logic [3:0] w_a_nib;
    logic [3:0] w_b_nib;
    logic [4:0] w_slice;
    logic       w_c3;

    assign w_a_nib = r_a[3:0];
    assign w_b_nib = r_b[3:0];
    assign w_slice = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
    // Carry into bit 3 of the slice, recovered from its sum bit.
    assign w_c3    = w_a_nib[3] ^ w_b_nib[3] ^ w_slice[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= cin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_sum[{r_cnt, 2'b00} +: 4] <= w_slice[3:0];
                    r_carry <= w_slice[4];
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_cout      <= w_slice[4];
                        r_ovf       <= w_c3 ^ w_slice[4];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Results stay held; no accept happens on this edge.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_rca_nibble_seq.sv
// Bench for rca_nibble_seq: WIDTH=16 and WIDTH=4 instances, directed table,
// multi-cycle corner sequences and random operands against an arithmetic model.
module tb_rca_nibble_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=16 instance
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;
    // WIDTH=4 instance
    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, ovf4;
    logic [3:0]  a4, b4, sum4;

    rca_nibble_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    rca_nibble_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer addition, overflow from operand/result signs.
    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic c);
        logic [16:0] t;
        logic        v;
        t = {1'b0, x} + {1'b0, y} + {16'd0, c};
        v = (x[15] == y[15]) && (t[15] != x[15]);
        return {t[16], v, t[15:0]};
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y,
                                          input logic c);
        logic [4:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {4'd0, c};
        v = (x[3] == y[3]) && (t[3] != x[3]);
        return {t[4], v, t[3:0]};
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    // One full transaction on the 16-bit instance: accept, wait for the result,
    // hold it under backpressure for 'hold' cycles (optionally pulsing in_valid),
    // then handshake and confirm the block returns to IDLE cleanly.
    task automatic run16(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                         input logic [15:0] es, input logic eco, input logic eov,
                         input int hold, input bit pulse);
        int          lat;
        logic [15:0] s0;
        @(negedge clk);
        chk("in_ready_before_accept", in_ready, 1'b1);
        a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~xa; b = ~xb; cin = ~xc;   // changes after capture must not matter
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency16", lat, 4);
        chk("sum16", sum, es);
        chk("cout16", cout, eco);
        chk("ovf16", ovf, eov);
        s0 = sum;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = pulse ? ~in_valid : 1'b0;
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_sum", sum, s0);
            chk("hold_cout_ovf", {cout, ovf}, {eco, eov});
            chk("hold_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_out_valid_low", out_valid, 1'b0);
        chk("hs_in_ready_high", in_ready, 1'b1);
        chk("hs_sum_kept", sum, s0);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("no_second_result", out_valid, 1'b0);
    endtask

    task automatic run4(input logic [3:0] xa, input logic [3:0] xb, input logic xc,
                        input logic [3:0] es, input logic eco, input logic eov);
        int lat;
        @(negedge clk);
        chk("in_ready4_before_accept", in_ready4, 1'b1);
        a4 = xa; b4 = xb; cin4 = xc; in_valid4 = 1'b1; out_ready4 = 1'b0;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency4", lat, 1);
        chk("sum4", sum4, es);
        chk("cout4", cout4, eco);
        chk("ovf4", ovf4, eov);
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        chk("hs4_out_valid_low", out_valid4, 1'b0);
        chk("hs4_in_ready_high", in_ready4, 1'b1);
        @(negedge clk);
        out_ready4 = 1'b0;
    endtask

    vec_t tbl[5];

    initial begin
        logic [17:0] m;
        logic [5:0]  m4;
        logic [15:0] ra, rb;
        logic        rc;
        logic [3:0]  ra4, rb4;

        in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 0;
        in_valid4 = 0; a4 = 0; b4 = 0; cin4 = 0; out_ready4 = 0;

        tbl[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_cout_ovf", {cout, ovf}, 2'b00);
        chk("rst_in_ready4", in_ready4, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 5; i++)
            run16(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, tbl[i].ov, 0, 1'b0);

        // Backpressure with ignored in_valid pulses
        run16(16'hB9D0, 16'h5D10, 1'b0, 16'h16E0, 1'b1, 1'b0, 5, 1'b1);

        // Asynchronous reset two cycles into an operation
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_sum", sum, 16'h0000);
        chk("midrst_cout_ovf", {cout, ovf}, 2'b00);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("postrst_no_result", out_valid, 1'b0);
        end
        chk("postrst_in_ready", in_ready, 1'b1);
        run16(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 0, 1'b0);

        // Random operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            m = model16(ra, rb, rc);
            run16(ra, rb, rc, m[15:0], m[17], m[16], $urandom_range(0, 2), 1'($urandom));
        end

        // WIDTH=4 instance
        run4(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
        run4(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            ra4 = 4'($urandom);
            rb4 = 4'($urandom);
            rc = 1'($urandom);
            m4 = model4(ra4, rb4, rc);
            run4(ra4, rb4, rc, m4[3:0], m4[5], m4[4]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
